// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter.
//   arb_state_e : arbiter FSM states (idle, request to memory, waiting for response)
//   arb_owner_e : which requester owns the outstanding transaction
//   SIZE_*      : memory access size encodings
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Optional feature macro: MEM_ARB_RR_EN (alternate winners on a tie).
//   ireq       : fetch request
//   dreq       : data request
//   last_owner : requester granted most recently (only consulted with MEM_ARB_RR_EN)
//   owner      : winner; only meaningful when ireq or dreq is high
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       ireq,
  input  logic       dreq,
  input  arb_owner_e last_owner,
  output arb_owner_e owner
);

  always_comb begin
    owner = OWN_DATA;
    if (ireq && !dreq) begin
      owner = OWN_IF;
    end else if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
      // Tie: the side that did not win last time gets the port.
      owner = (last_owner == OWN_IF) ? OWN_DATA : OWN_IF;
`else
      owner = OWN_DATA;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority never looks at the history input.
  arb_owner_e unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// with at most one transaction outstanding.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on ties; default is data-first).
// Ports:
//   clk_i, rst_ni                        : clock, async active-low reset
//   ireq_i, iaddr_i                      : fetch request and address
//   igrant_o, irvalid_o, irdata_o        : fetch accepted, fetch data valid, fetch data
//   dreq_i, dwe_i, daddr_i, dwdata_i, dsize_i : data request, store flag, address, store data, size
//   dgrant_o, drvalid_o, drdata_o        : data accepted, load data/store ack valid, load data
//   mem_req_o .. mem_size_o              : request to memory (driven only in ARB_REQ)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : memory accept, response valid, read data
//   busy_o                               : transaction in progress
//   state_o                              : FSM state, for observation
// Handshake: a requester holds req and its fields stable until its grant
// pulse; the grant is combinational in ARB_IDLE and the fields are captured
// on that same edge. The memory accepts in the cycle mem_req_o && mem_gnt_i
// and answers later with a one-cycle mem_rvalid_i.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ireq_i,
  input  logic [AWIDTH-1:0] iaddr_i,
  output logic              igrant_o,
  output logic              irvalid_o,
  output logic [DWIDTH-1:0] irdata_o,
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [AWIDTH-1:0] daddr_i,
  input  logic [DWIDTH-1:0] dwdata_i,
  input  logic [1:0]        dsize_i,
  output logic              dgrant_o,
  output logic              drvalid_o,
  output logic [DWIDTH-1:0] drdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic [1:0]        mem_size_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              busy_o,
  output arb_state_e        state_o
);

  arb_state_e        state_q, state_d;
  arb_owner_e        own_q, own_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  arb_owner_e        pick_owner;
  arb_owner_e        pick_last;

`ifdef MEM_ARB_RR_EN
  arb_owner_e        last_q, last_d;
  assign pick_last = last_q;
`else
  assign pick_last = OWN_DATA;
`endif

  mem_arb_pick u_pick (
    .ireq       (ireq_i),
    .dreq       (dreq_i),
    .last_owner (pick_last),
    .owner      (pick_owner)
  );

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    igrant_o    = 1'b0;
    dgrant_o    = 1'b0;
    irvalid_o   = 1'b0;
    irdata_o    = '0;
    drvalid_o   = 1'b0;
    drdata_o    = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_size_o  = 2'b00;

    case (state_q)
      ARB_IDLE: begin
        if (ireq_i || dreq_i) begin
          if (pick_owner == OWN_DATA) begin
            dgrant_o = 1'b1;
            we_d     = dwe_i;
            addr_d   = daddr_i;
            wdata_d  = dwdata_i;
            size_d   = dsize_i;
          end else begin
            // Fetches are always word reads.
            igrant_o = 1'b1;
            we_d     = 1'b0;
            addr_d   = iaddr_i;
            wdata_d  = '0;
            size_d   = SIZE_WORD;
          end
          own_d   = pick_owner;
`ifdef MEM_ARB_RR_EN
          last_d  = pick_owner;
`endif
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_size_o  = size_q;
        if (mem_gnt_i) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rvalid_i) begin
          if (own_q == OWN_DATA) begin
            drvalid_o = 1'b1;
            drdata_o  = mem_rdata_i;
          end else begin
            irvalid_o = 1'b1;
            irdata_o  = mem_rdata_i;
          end
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      own_q   <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
`ifdef MEM_ARB_RR_EN
      // Starting at DATA makes the first tie after reset go to fetch.
      last_q  <= OWN_DATA;
`endif
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign busy_o  = (state_q != ARB_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, a memory responder with configurable accept delay, and directed
// scenarios with literal expectations.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic          ireq_i = 1'b0;
  logic [AW-1:0] iaddr_i = '0;
  logic          igrant_o, irvalid_o;
  logic [DW-1:0] irdata_o;
  logic          dreq_i = 1'b0, dwe_i = 1'b0;
  logic [AW-1:0] daddr_i = '0;
  logic [DW-1:0] dwdata_i = '0;
  logic [1:0]    dsize_i = 2'b00;
  logic          dgrant_o, drvalid_o;
  logic [DW-1:0] drdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [1:0]    mem_size_o;
  logic          mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          busy_o;
  arb_state_e    state_o;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i),
    .igrant_o(igrant_o), .irvalid_o(irvalid_o), .irdata_o(irdata_o),
    .dreq_i(dreq_i), .dwe_i(dwe_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i), .dsize_i(dsize_i),
    .dgrant_o(dgrant_o), .drvalid_o(drvalid_o), .drdata_o(drdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .state_o(state_o)
  );

  int total = 0;
  int bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- memory responder ----------------
  int            gnt_delay = 0;
  bit            hold_resp = 1'b0;
  bit            spur = 1'b0;
  logic [DW-1:0] resp_data = '0;
  int            wait_cnt = 0;
  bit            pend = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_ni) begin
      wait_cnt = 0;
      pend = 1'b0;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = spur;
      mem_rdata_i = spur ? resp_data : '0;
    end else begin
      mem_rvalid_i = (pend && !hold_resp) || spur;
      mem_rdata_i  = mem_rvalid_i ? resp_data : '0;
      pend = 1'b0;
      if (mem_req_o) begin
        if (wait_cnt >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          wait_cnt = 0;
          pend = 1'b1;
        end else begin
          mem_gnt_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_gnt_i = 1'b0;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // One outstanding transaction record: in flight, accepted by memory, owner, fields.
  bit            m_busy = 0, m_issued = 0, m_data = 0, m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [1:0]    m_size = '0;
  bit            m_last_data = 1'b1;

  initial forever begin
    bit            n_busy, n_issued, n_data, n_we, n_last, win_d, tie_d;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_wdata;
    logic [1:0]    n_size;
    bit            e_ig, e_dg, e_irv, e_drv, e_req, e_we;
    logic [DW-1:0] e_ird, e_drd, e_wd;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_size;
    arb_state_e    e_state;
    @(negedge clk);
    #2;
    if (!rst_ni) begin
      m_busy = 0; m_issued = 0; m_data = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_size = '0; m_last_data = 1'b1;
    end
    n_busy = m_busy; n_issued = m_issued; n_data = m_data; n_we = m_we;
    n_addr = m_addr; n_wdata = m_wdata; n_size = m_size; n_last = m_last_data;
    e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_req = 0; e_we = 0;
    e_ird = '0; e_drd = '0; e_wd = '0; e_addr = '0; e_size = '0;
    if (rst_ni) begin
      if (!m_busy) begin
        if (ireq_i || dreq_i) begin
`ifdef MEM_ARB_RR_EN
          tie_d = !m_last_data;
`else
          tie_d = 1'b1;
`endif
          win_d = dreq_i && (!ireq_i || tie_d);
          e_dg = win_d;
          e_ig = !win_d;
          n_busy = 1; n_issued = 0; n_data = win_d; n_last = win_d;
          n_we    = win_d ? dwe_i : 1'b0;
          n_addr  = win_d ? daddr_i : iaddr_i;
          n_wdata = win_d ? dwdata_i : '0;
          n_size  = win_d ? dsize_i : 2'b10;
        end
      end else if (!m_issued) begin
        e_req = 1; e_we = m_we; e_addr = m_addr; e_wd = m_wdata; e_size = m_size;
        if (mem_gnt_i) n_issued = 1;
      end else if (mem_rvalid_i) begin
        e_drv = m_data;
        e_irv = !m_data;
        e_drd = m_data ? mem_rdata_i : '0;
        e_ird = m_data ? '0 : mem_rdata_i;
        n_busy = 0; n_issued = 0;
      end
    end
    e_state = !m_busy ? ARB_IDLE : (m_issued ? ARB_WAIT : ARB_REQ);
    chk("igrant", 64'(igrant_o), 64'(e_ig));
    chk("dgrant", 64'(dgrant_o), 64'(e_dg));
    chk("irvalid", 64'(irvalid_o), 64'(e_irv));
    chk("irdata", 64'(irdata_o), 64'(e_ird));
    chk("drvalid", 64'(drvalid_o), 64'(e_drv));
    chk("drdata", 64'(drdata_o), 64'(e_drd));
    chk("mem_req", 64'(mem_req_o), 64'(e_req));
    chk("mem_we", 64'(mem_we_o), 64'(e_we));
    chk("mem_addr", 64'(mem_addr_o), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata_o), 64'(e_wd));
    chk("mem_size", 64'(mem_size_o), 64'(e_size));
    chk("busy", 64'(busy_o), 64'(m_busy));
    chk("state", 64'(state_o), 64'(e_state));
    @(posedge clk);
    if (rst_ni) begin
      m_busy = n_busy; m_issued = n_issued; m_data = n_data; m_we = n_we;
      m_addr = n_addr; m_wdata = n_wdata; m_size = n_size; m_last_data = n_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #3;
  endtask

  task automatic do_reset();
    drive();
    rst_ni = 1'b0;
    ireq_i = 1'b0; dreq_i = 1'b0; dwe_i = 1'b0;
    gnt_delay = 0; hold_resp = 1'b0; spur = 1'b0;
    drive();
    drive();
    rst_ni = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bit          first_data;
    logic [3:0]  seq;
    int          n_gr;

    do_reset();

    // Fetch only, immediate memory accept.
    ireq_i = 1'b1; iaddr_i = 32'h0100_0000; resp_data = 32'h0000_0013;
    sample();
    chk("t1_igrant_c0", 64'(igrant_o), 64'h1);
    drive(); ireq_i = 1'b0;
    sample();
    chk("t1_mem_req_c1", 64'(mem_req_o), 64'h1);
    chk("t1_mem_addr_c1", 64'(mem_addr_o), 64'h0100_0000);
    chk("t1_mem_size_c1", 64'(mem_size_o), 64'h2);
    drive();
    sample();
    chk("t1_irvalid_c2", 64'(irvalid_o), 64'h1);
    chk("t1_irdata_c2", 64'(irdata_o), 64'h13);
    drive();
    sample();
    chk("t1_idle_c3", 64'(busy_o), 64'h0);

    // Simultaneous fetch and load.
    do_reset();
`ifdef MEM_ARB_RR_EN
    first_data = 1'b0;
`else
    first_data = 1'b1;
`endif
    ireq_i = 1'b1; iaddr_i = 32'h0100_0004;
    dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h0100_0040; dsize_i = 2'b10; dwdata_i = '0;
    resp_data = 32'h0000_0055;
    sample();
    chk("t2_dgrant_c0", 64'(dgrant_o), 64'(first_data));
    chk("t2_igrant_c0", 64'(igrant_o), 64'(!first_data));
    drive();
    if (first_data) dreq_i = 1'b0; else ireq_i = 1'b0;
    sample();
    chk("t2_no_grant_c1", 64'(igrant_o | dgrant_o), 64'h0);
    drive();
    sample();
    chk("t2_rvalid_c2", 64'(first_data ? drvalid_o : irvalid_o), 64'h1);
    chk("t2_no_grant_c2", 64'(igrant_o | dgrant_o), 64'h0);
    drive();
    sample();
    chk("t2_second_grant_c3", 64'(first_data ? igrant_o : dgrant_o), 64'h1);
    drive();
    ireq_i = 1'b0; dreq_i = 1'b0;
    drive();
    drive();
    sample();
    chk("t2_idle", 64'(busy_o), 64'h0);

    // Both requesters held across four transactions.
    do_reset();
    ireq_i = 1'b1; dreq_i = 1'b1; dwe_i = 1'b0;
    seq = '0; n_gr = 0;
    for (int c = 0; c < 40 && n_gr < 4; c++) begin
      sample();
      if (igrant_o || dgrant_o) begin
        seq[n_gr] = dgrant_o;
        n_gr++;
      end
      drive();
    end
    ireq_i = 1'b0; dreq_i = 1'b0;
    chk("t3_grant_count", 64'(n_gr), 64'd4);
`ifdef MEM_ARB_RR_EN
    chk("t3_grant_order", 64'(seq), 64'b1010);
`else
    chk("t3_grant_order", 64'(seq), 64'b1111);
`endif
    drive();
    drive();
    drive();

    // Store with the memory accepting only after three wait cycles.
    do_reset();
    gnt_delay = 3; resp_data = 32'h0000_0077;
    dreq_i = 1'b1; dwe_i = 1'b1; daddr_i = 32'h0100_0080; dwdata_i = 32'hDEAD_BEEF; dsize_i = 2'b10;
    sample();
    chk("t4_dgrant_c0", 64'(dgrant_o), 64'h1);
    drive();
    dreq_i = 1'b0; daddr_i = 32'h1111_1111; dwdata_i = 32'h2222_2222; dsize_i = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      sample();
      chk("t4_mem_req", 64'(mem_req_o), 64'h1);
      chk("t4_mem_we", 64'(mem_we_o), 64'h1);
      chk("t4_mem_addr", 64'(mem_addr_o), 64'h0100_0080);
      chk("t4_mem_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
      chk("t4_mem_size", 64'(mem_size_o), 64'h2);
      drive();
    end
    sample();
    chk("t4_mem_req_off", 64'(mem_req_o), 64'h0);
    chk("t4_drvalid", 64'(drvalid_o), 64'h1);
    chk("t4_drdata", 64'(drdata_o), 64'h77);
    drive();
    gnt_delay = 0;

    // Reset while waiting for the response, then a stray response.
    do_reset();
    hold_resp = 1'b1;
    ireq_i = 1'b1; iaddr_i = 32'h0100_0010; resp_data = 32'h0000_00AA;
    sample();
    chk("t5_igrant", 64'(igrant_o), 64'h1);
    drive(); ireq_i = 1'b0;
    drive();
    sample();
    chk("t5_in_wait", 64'(state_o), 64'(ARB_WAIT));
    drive();
    rst_ni = 1'b0;
    sample();
    chk("t5_rst_outputs", 64'({busy_o, igrant_o, dgrant_o, irvalid_o, drvalid_o, mem_req_o, mem_we_o}), 64'h0);
    chk("t5_rst_size", 64'(mem_size_o), 64'h0);
    chk("t5_rst_state", 64'(state_o), 64'(ARB_IDLE));
    drive();
    rst_ni = 1'b1; hold_resp = 1'b0; spur = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("t5_no_irvalid", 64'(irvalid_o), 64'h0);
      chk("t5_no_drvalid", 64'(drvalid_o), 64'h0);
      chk("t5_irdata_zero", 64'(irdata_o), 64'h0);
      chk("t5_idle_state", 64'(state_o), 64'(ARB_IDLE));
      drive();
    end
    spur = 1'b0;
    drive();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: AWIDTH, default 32, address width; DWIDTH, default 32, data width.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 ireq_i  input  1  fetch request; held with iaddr_i stable until igrant_o.
REQ-005 iaddr_i  input  AWIDTH  fetch address.
REQ-006 igrant_o / irvalid_o  output  1 each  fetch accepted pulse / fetch data valid pulse.
REQ-007 irdata_o  output  DWIDTH  fetch data; valid only with irvalid_o.
REQ-008 dreq_i, dwe_i  input  1 each  data request (load or store); store when dwe_i=1; held stable until dgrant_o.
REQ-009 daddr_i, dwdata_i, dsize_i  input  AWIDTH, DWIDTH, 2  data address, store data, size (00 byte, 01 half, 10 word).
REQ-010 dgrant_o / drvalid_o  output  1 each  data accepted pulse / load data or store acknowledge pulse.
REQ-011 drdata_o  output  DWIDTH  load data; valid only with drvalid_o.
REQ-012 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o  output  1, 1, AWIDTH, DWIDTH, 2  request to the shared single-port memory.
REQ-013 mem_gnt_i, mem_rvalid_i, mem_rdata_i  input  1, 1, DWIDTH  memory accept, response valid, read data.
REQ-014 busy_o  output  1  high whenever state is not ARB_IDLE.

Function
REQ-015 The FSM SHALL have three states, ARB_IDLE, ARB_REQ and ARB_WAIT, with at most one transaction outstanding.
REQ-016 ARB_IDLE: with any request present, the winner's grant SHALL assert combinationally in the same cycle, its fields SHALL be latched into holding registers with the owner, and the FSM SHALL move to ARB_REQ.
REQ-017 Fixed priority SHALL be the default: data wins over fetch on simultaneous ireq_i and dreq_i.
REQ-018 ARB_REQ: mem_req_o=1 and the mem_* fields SHALL be driven from the holding registers; on mem_gnt_i the FSM SHALL move to ARB_WAIT, otherwise it SHALL stay.
REQ-019 ARB_WAIT: on mem_rvalid_i, the owner's rvalid_o SHALL pulse in that cycle with rdata_o=mem_rdata_i, and the FSM SHALL return to ARB_IDLE.
REQ-020 Minimum latency SHALL be: grant cycle 0, mem_req_o cycle 1 (mem_gnt_i=1), rvalid_o cycle 2, next grant no earlier than cycle 3.
REQ-021 mem_rvalid_i SHALL be ignored in ARB_IDLE and ARB_REQ; mem_gnt_i SHALL be ignored outside ARB_REQ.
REQ-022 New requests arriving while busy_o=1 SHALL receive no grant until the FSM returns to ARB_IDLE.
REQ-023 A store SHALL complete on mem_rvalid_i, with drvalid_o=1 and drdata_o=mem_rdata_i (don't-care to the consumer).
REQ-024 Non-owner rvalid/rdata outputs SHALL be 0; mem_we_o, mem_wdata_o and mem_size_o SHALL be 0 and 2'b10 respectively for fetch transactions.

Reset
REQ-025 Reset SHALL set state=ARB_IDLE, all holding registers=0, and every output to 0 (mem_size_o=0); the round-robin pointer SHALL reset to DATA.
REQ-026 Reset asserted mid-transaction SHALL abandon it, with no rvalid pulse emitted afterwards for that transaction.

Configuration
REQ-027 With MEM_ARB_RR_EN defined, on simultaneous requests the requester not granted most recently SHALL win, and the pointer SHALL update on every grant; the first tie after reset SHALL go to fetch.
REQ-028 Without MEM_ARB_RR_EN, the fixed data-first priority of REQ-017 SHALL apply and no pointer flop SHALL exist.

Structure
REQ-029 arb_state_e (ARB_IDLE, ARB_REQ, ARB_WAIT) and arb_owner_e (OWN_IF, OWN_DATA) SHALL reside in the shared constants package.
REQ-030 Winner selection SHALL be a combinational sub-module, mem_arb_pick (inputs ireq, dreq, last_owner; output owner).

Verification
REQ-031 Fetch only: ireq_i=1, iaddr_i=0x0100_0000, mem_gnt_i immediate, rvalid next cycle with 0x0000_0013 -> igrant_o cycle 0, mem_addr_o=0x0100_0000 cycle 1, irvalid_o with irdata_o=0x13 cycle 2.
REQ-032 Tie, fixed priority: ireq_i=dreq_i=1 (load 0x0100_0040) -> dgrant_o first; fetch granted cycle 3 after drvalid_o.
REQ-033 Tie with MEM_ARB_RR_EN, both held for 4 transactions -> grants in the order IF, DATA, IF, DATA.
REQ-034 Store with mem_gnt_i delayed 3 cycles: daddr_i=0x0100_0080, dwdata_i=0xDEAD_BEEF, dsize_i=10 -> mem_req_o held 4 cycles with fields stable, mem_we_o=1, drvalid_o on mem_rvalid_i.
REQ-035 rst_ni dropped in ARB_WAIT, then spurious mem_rvalid_i after release -> all outputs 0, no irvalid_o/drvalid_o, state ARB_IDLE.
